// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating counters
// Optional BP_STATS_EN adds saturating branch and mispredict counters.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pcF,
  output logic            predTakenF,
  output logic [XLEN-1:0] predTargetF,
  input  logic            updEnE,
  input  logic [XLEN-1:0] pcE,
  input  logic            takenE,
  input  logic [XLEN-1:0] targetE,
  input  logic            predTakenE,
  input  logic [XLEN-1:0] predTargetE,
  output logic            mispredictE,
  output logic [XLEN-1:0] redirectPCE
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     branchCnt,
  output logic [31:0]     mispredCnt
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_idx_f;
  logic [TAG_W-1:0] w_tag_f;
  logic             w_hit_f;
  logic [IDX_W-1:0] w_idx_e;
  logic [TAG_W-1:0] w_tag_e;
  logic             w_hit_e;
  logic             w_unused_lsb;

  // Instructions are word aligned, so the two low PC bits carry no information.
  assign w_unused_lsb = ^{pcF[1:0], pcE[1:0]};

  assign w_idx_f = pcF[IDX_W+1:2];
  assign w_tag_f = pcF[XLEN-1:IDX_W+2];
  assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);

  assign predTakenF  = w_hit_f && r_ctr[w_idx_f][1];
  assign predTargetF = predTakenF ? r_target[w_idx_f] : '0;

  assign w_idx_e = pcE[IDX_W+1:2];
  assign w_tag_e = pcE[XLEN-1:IDX_W+2];
  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

  assign mispredictE = updEnE && ((takenE != predTakenE) ||
                                  (takenE && predTakenE && (targetE != predTargetE)));
  assign redirectPCE = takenE ? targetE : (pcE + XLEN'(4));

  // Lookup reads registered state, so a same-cycle update shows up next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (updEnE) begin
      if (w_hit_e) begin
        if (takenE) begin
          if (r_ctr[w_idx_e] != 2'b11) r_ctr[w_idx_e] <= r_ctr[w_idx_e] + 2'b01;
          r_target[w_idx_e] <= targetE;
        end else if (r_ctr[w_idx_e] != 2'b00) begin
          r_ctr[w_idx_e] <= r_ctr[w_idx_e] - 2'b01;
        end
      end else if (takenE) begin
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= targetE;
        r_ctr[w_idx_e]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (updEnE && (r_branch_cnt != 32'hFFFF_FFFF))       r_branch_cnt  <= r_branch_cnt + 32'd1;
      if (mispredictE && (r_mispred_cnt != 32'hFFFF_FFFF)) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign branchCnt  = r_branch_cnt;
  assign mispredCnt = r_mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
// Define BP_STATS_EN for both files to also check the statistics counters.
module tb_branch_predictor;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] pcF = '0;
  logic            predTakenF;
  logic [XLEN-1:0] predTargetF;
  logic            updEnE = 1'b0;
  logic [XLEN-1:0] pcE = '0;
  logic            takenE = 1'b0;
  logic [XLEN-1:0] targetE = '0;
  logic            predTakenE = 1'b0;
  logic [XLEN-1:0] predTargetE = '0;
  logic            mispredictE;
  logic [XLEN-1:0] redirectPCE;
`ifdef BP_STATS_EN
  logic [31:0]     branchCnt;
  logic [31:0]     mispredCnt;
`endif

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(predTakenF), .predTargetF(predTargetF),
    .updEnE(updEnE), .pcE(pcE), .takenE(takenE), .targetE(targetE),
    .predTakenE(predTakenE), .predTargetE(predTargetE),
    .mispredictE(mispredictE), .redirectPCE(redirectPCE)
`ifdef BP_STATS_EN
    , .branchCnt(branchCnt), .mispredCnt(mispredCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pt;
    logic [31:0] ptg;
    logic        mis;
    logic [31:0] redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a table of entries addressed by (pc/4) mod ENTRIES.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_bc, m_mc;
  bit          pend_upd, pend_taken, pend_mis;
  logic [31:0] pend_pc, pend_tgt;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = m_idx(pc);
    return m_valid[i] && (m_tag[i] == pc / (4 * ENTRIES));
  endfunction

  task automatic m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i = m_idx(pc);
    t  = m_hit(pc) && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : 32'd0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    int i = m_idx(pc);
    if (m_hit(pc)) begin
      m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      if (tk) m_tgt[i] = tg;
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc / (4 * ENTRIES);
      m_tgt[i]   = tg;
      m_ctr[i]   = 2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: commit the previous cycle's update at the edge, then drive new inputs.
  task automatic cycle(input bit r, input bit upd, input logic [31:0] pcf, input logic [31:0] pce,
                       input bit tk, input logic [31:0] tge, input bit ptk, input logic [31:0] ptg);
    exp_t e;
    bit   t;
    logic [31:0] tg;
    @(posedge clk);
    if (pend_upd) begin
      m_update(pend_pc, pend_taken, pend_tgt);
      m_bc++;
    end
    if (pend_mis) m_mc++;
    #1;
    rst = r; updEnE = upd; pcF = pcf; pcE = pce; takenE = tk; targetE = tge;
    predTakenE = ptk; predTargetE = ptg;
    if (!r) m_reset();
    m_lookup(pcf, t, tg);
    e.pt    = t;
    e.ptg   = tg;
    e.mis   = upd && ((tk != ptk) || (tk && ptk && (tge != ptg)));
    e.redir = tk ? tge : pce + 32'd4;
    e.bc    = m_bc;
    e.mc    = m_mc;
    pend_upd   = r && upd;
    pend_mis   = r && e.mis;
    pend_pc    = pce;
    pend_taken = tk;
    pend_tgt   = tge;
    q.push_back(e);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("predTakenF", 32'(predTakenF), 32'(e.pt));
        chk("predTargetF", predTargetF, e.ptg);
        chk("mispredictE", 32'(mispredictE), 32'(e.mis));
        if (e.mis) chk("redirectPCE", redirectPCE, e.redir);
`ifdef BP_STATS_EN
        chk("branchCnt", branchCnt, e.bc);
        chk("mispredCnt", mispredCnt, e.mc);
`endif
      end
    end
  end

  initial begin : stimulus
    logic [31:0] pce, pcf, tge, ptg;
    bit ptk;
    m_reset();
    pend_upd = 0; pend_mis = 0; pend_pc = 0; pend_taken = 0; pend_tgt = 0;

    cycle(0, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);
    cycle(1, 1, 32'h40, 32'h40, 1, 32'h80, 0, 32'h0);
    cycle(1, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);
    cycle(1, 1, 32'h40, 32'h40, 0, 32'h0, 1, 32'h80);
    cycle(1, 1, 32'h40, 32'h40, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);
    cycle(1, 1, 32'h40, 32'h40, 0, 32'h0, 0, 32'h0);
    cycle(1, 1, 32'h40, 32'h40, 1, 32'h80, 0, 32'h0);
    cycle(1, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);
    cycle(0, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);
    cycle(1, 1, 32'h0, 32'h40, 1, 32'h100, 0, 32'h0);
    cycle(1, 1, 32'h0, 32'h80, 1, 32'h200, 0, 32'h0);
    cycle(1, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 32'h80, 32'h0, 0, 32'h0, 0, 32'h0);
    cycle(1, 1, 32'h0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0);
    cycle(1, 1, 32'h40, 32'h40, 1, 32'h300, 0, 32'h0);
    cycle(0, 1, 32'h40, 32'h40, 1, 32'h300, 0, 32'h0);
    cycle(1, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      pce = rand_pc();
      pcf = ($urandom_range(0, 3) == 0) ? pce : rand_pc();
      tge = 32'($urandom_range(1, 4)) << 8;
      if ($urandom_range(0, 1) == 1) m_lookup(pce, ptk, ptg);
      else begin
        ptk = 1'($urandom_range(0, 1));
        ptg = 32'($urandom_range(0, 4)) << 8;
      end
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), pcf, pce,
            1'($urandom_range(0, 1)), tge, ptk, ptg);
    end
    cycle(1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
